// File: rtl/hashin_reader_pkg.sv
// Shared miner definitions: job framing constants, header geometry and the
// reader FSM state encoding. Also imported by the nonce generator.
// Pure declarations; no logic, no latency, no flow control.
package hashin_reader_pkg;

  // Job-start marker and default header length (64-bit words after the marker)
  localparam logic [63:0] PREAMBLE_DEF = 64'h8000000000000280;
  localparam int unsigned WORDS_DEF    = 10;

  // 80-byte block header
  localparam int unsigned HDR_W   = 640;
  localparam int unsigned NONCE_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LOAD,
    ST_NONCE,
    ST_CHECK,
    ST_PRESENT
  } state_t;

  // The nonce field sits little-endian in the last 32 bits of the header;
  // return it as a plain 32-bit number for comparison with the nonce FIFO.
  function automatic logic [NONCE_W-1:0] hdr_nonce(input logic [HDR_W-1:0] hdr);
    return {hdr[7:0], hdr[15:8], hdr[23:16], hdr[31:24]};
  endfunction

endpackage

// File: rtl/hashin_reader_if.sv
// Bundle of the two FIFO read ports and the job handoff to the hash core.
// Wires only; read data is expected one cycle after an accepted read.
// Job handoff is valid/ready; FIFO side is read-enable/empty.
//
// master: the reader (drives read enables and the job), slave: FIFOs + core.
interface hashin_reader_if;
  import hashin_reader_pkg::*;

  logic                 hashin_fifo_empty;
  logic                 hashin_fifo_re;
  logic [63:0]          hashin_fifo_dout;
  logic                 nonce_fifo_empty;
  logic                 nonce_fifo_re;
  logic [NONCE_W-1:0]   nonce_fifo_dout;
  logic                 job_valid;
  logic                 job_ready;
  logic [HDR_W-1:0]     job_header;
  logic [NONCE_W-1:0]   job_nonce;

  modport master (
    input  hashin_fifo_empty, hashin_fifo_dout,
    input  nonce_fifo_empty,  nonce_fifo_dout,
    input  job_ready,
    output hashin_fifo_re, nonce_fifo_re,
    output job_valid, job_header, job_nonce
  );

  modport slave (
    output hashin_fifo_empty, hashin_fifo_dout,
    output nonce_fifo_empty,  nonce_fifo_dout,
    output job_ready,
    input  hashin_fifo_re, nonce_fifo_re,
    input  job_valid, job_header, job_nonce
  );

endinterface

// File: rtl/hashin_reader_job_out.sv
// Job output register: holds one assembled header/nonce for the hash core.
// Latency: valid rises the cycle after load; clears the cycle after valid&&ready.
// Backpressure: contents held stable while valid && !ready; load only when empty.
//
// Ports: clk, rst_n (sync, active-low), load/header_in/nonce_in from the reader,
// ready from the core, valid/header/nonce to the core.
module job_out_reg
  import hashin_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [HDR_W-1:0]     header_in,
  input  logic [NONCE_W-1:0]   nonce_in,
  input  logic                 ready,
  output logic                 valid,
  output logic [HDR_W-1:0]     header,
  output logic [NONCE_W-1:0]   nonce
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      header <= '0;
      nonce  <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      header <= header_in;
      nonce  <= nonce_in;
    end else if (valid && ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/hashin_reader.sv
// Hashin reader: hunts for the preamble, gathers WORDS header words plus a nonce,
// checks the embedded nonce and hands the job to the hash core.
// Latency: last header word captured -> job_valid in 3 cycles (nonce FIFO non-empty).
// Backpressure: no FIFO reads while a job waits for job_ready; stop aborts reads at once.
//
// Ports: clk, rst_n (sync, active-low), stop (level abort), bus (FIFO reads + job
// handoff, master side), stop_ack (high in IDLE), sync_err_cnt (saturating count of
// words discarded while hunting), nonce_err (sticky header/nonce mismatch flag).
module hashin_reader
  import hashin_reader_pkg::*;
#(
  parameter int unsigned WORDS    = WORDS_DEF,
  parameter logic [63:0] PREAMBLE = PREAMBLE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stop,
  hashin_reader_if.master       bus,
  output logic                  stop_ack,
  output logic [15:0]           sync_err_cnt,
  output logic                  nonce_err
);

  localparam int unsigned    CNT_W   = $clog2(WORDS + 1);
  localparam logic [CNT_W:0] WORDS_C = (CNT_W + 1)'(WORDS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WORDS - 1);

  state_t               state_q, state_d;
  logic [HDR_W-1:0]     header_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic                 hrd_pend_q;   // hashin data arrives this cycle
  logic                 nrd_pend_q;   // nonce data arrives this cycle
  logic [15:0]          err_cnt_q;
  logic                 nonce_err_q;

  logic                 hre;
  logic                 nre;
  logic                 job_load;
  logic [CNT_W:0]       committed;    // words captured or already in flight

  assign committed = {1'b0, cnt_q} + (CNT_W + 1)'(hrd_pend_q);

  // Next state and read enables
  always_comb begin
    state_d  = state_q;
    hre      = 1'b0;
    nre      = 1'b0;
    job_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!stop) state_d = ST_HUNT;
      end
      ST_HUNT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          // Keep streaming: a read issued alongside the preamble capture
          // returns header word 0 in the first LOAD cycle.
          hre = !bus.hashin_fifo_empty;
          if (hrd_pend_q && bus.hashin_fifo_dout == PREAMBLE) state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          // Never put more than WORDS reads in flight for this job.
          hre = !bus.hashin_fifo_empty && (committed < WORDS_C);
          if (hrd_pend_q && cnt_q == LAST_C) begin
            state_d = ST_NONCE;
            // Fetch the nonce together with the last header capture to
            // shorten the path to job_valid.
            nre = !bus.nonce_fifo_empty;
          end
        end
      end
      ST_NONCE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (nrd_pend_q) begin
          state_d = ST_CHECK;
        end else begin
          nre = !bus.nonce_fifo_empty;
        end
      end
      ST_CHECK: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          job_load = 1'b1;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // Abort waits for the pending handshake to finish.
        if (bus.job_valid && bus.job_ready) state_d = stop ? ST_IDLE : ST_HUNT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads are suppressed combinationally during reset so the reset cycle
  // itself never pops a FIFO.
  assign bus.hashin_fifo_re = hre & rst_n;
  assign bus.nonce_fifo_re  = nre & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      header_q    <= '0;
      cnt_q       <= '0;
      nonce_q     <= '0;
      hrd_pend_q  <= 1'b0;
      nrd_pend_q  <= 1'b0;
      err_cnt_q   <= '0;
      nonce_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hrd_pend_q <= bus.hashin_fifo_re;
      nrd_pend_q <= bus.nonce_fifo_re;
      // Data arriving in an abort cycle or in IDLE is dropped.
      unique case (state_q)
        ST_IDLE: begin
          header_q <= '0;
          cnt_q    <= '0;
        end
        ST_HUNT: begin
          if (!stop && hrd_pend_q) begin
            if (bus.hashin_fifo_dout == PREAMBLE) begin
              header_q <= '0;
              cnt_q    <= '0;
            end else if (err_cnt_q != 16'hFFFF) begin
              err_cnt_q <= err_cnt_q + 16'd1;
            end
          end
        end
        ST_LOAD: begin
          // Preamble values here are ordinary header data.
          if (!stop && hrd_pend_q) begin
            header_q <= {header_q[HDR_W-65:0], bus.hashin_fifo_dout};
            cnt_q    <= cnt_q + CNT_W'(1);
          end
        end
        ST_NONCE: begin
          if (!stop && nrd_pend_q) nonce_q <= bus.nonce_fifo_dout;
        end
        ST_CHECK: begin
          if (!stop && hdr_nonce(header_q) != nonce_q) nonce_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  job_out_reg u_job_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (job_load),
    .header_in (header_q),
    .nonce_in  (nonce_q),
    .ready     (bus.job_ready),
    .valid     (bus.job_valid),
    .header    (bus.job_header),
    .nonce     (bus.job_nonce)
  );

  assign stop_ack     = (state_q == ST_IDLE);
  assign sync_err_cnt = err_cnt_q;
  assign nonce_err    = nonce_err_q;

endmodule

// File: tb/tb_hashin_reader.sv
// Bench for hashin_reader: FIFO models as queues, jobs built from random words,
// expected header/nonce/error counters computed from the framing rules.
module tb_hashin_reader;

  localparam logic [63:0] PRE = 64'h8000000000000280;

  logic clk = 1'b0;
  logic rst_n;
  logic stop;
  logic stop_ack;
  logic [15:0] sync_err_cnt;
  logic nonce_err;

  hashin_reader_if bus();

  hashin_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stop         (stop),
    .bus          (bus),
    .stop_ack     (stop_ack),
    .sync_err_cnt (sync_err_cnt),
    .nonce_err    (nonce_err)
  );

  always #5 clk = ~clk;

  logic [63:0] hq[$];
  logic [31:0] nq[$];
  int hreads = 0;
  int cyc = 0;
  int last_pop = 0;
  int n_assert = 0;
  int n_fail = 0;
  int exp_sync = 0;
  bit exp_nerr = 1'b0;

  // FIFO models: pop on an accepted read, data visible the following cycle.
  always @(posedge clk) begin
    cyc++;
    if (bus.hashin_fifo_re && !bus.hashin_fifo_empty && hq.size() > 0) begin
      bus.hashin_fifo_dout <= hq.pop_front();
      hreads++;
      last_pop = cyc;
    end
    if (bus.nonce_fifo_re && !bus.nonce_fifo_empty && nq.size() > 0)
      bus.nonce_fifo_dout <= nq.pop_front();
  end

  always @(negedge clk) begin
    bus.hashin_fifo_empty = (hq.size() == 0);
    bus.nonce_fifo_empty  = (nq.size() == 0);
  end

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue garbage, a preamble, ten header words and a nonce. The last
  // header word carries the nonce byte-reversed, optionally corrupted.
  task automatic push_job(input int garb, input bit good, input int pre_at,
                          output logic [639:0] hdr, output logic [31:0] nn);
    logic [63:0] w;
    logic [31:0] le;
    for (int i = 0; i < garb; i++) begin
      w = {$urandom, $urandom};
      if (w == PRE) w = w ^ 64'h1;
      hq.push_back(w);
    end
    hq.push_back(PRE);
    nn = $urandom;
    le = {nn[7:0], nn[15:8], nn[23:16], nn[31:24]};
    hdr = '0;
    for (int i = 0; i < 10; i++) begin
      w = {$urandom, $urandom};
      if (i == pre_at) w = PRE;
      if (i == 9) w[31:0] = good ? le : (le ^ 32'h0000_0100);
      hdr[639 - 64*i -: 64] = w;
      hq.push_back(w);
    end
    nq.push_back(nn);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.job_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_seen"}, bus.job_valid, 1'b1);
  endtask

  task automatic accept(input string tag, input int delay);
    repeat (delay) @(negedge clk);
    bus.job_ready = 1'b1;
    @(negedge clk);
    bus.job_ready = 1'b0;
    check({tag, "_valid_drop"}, bus.job_valid, 1'b0);
  endtask

  task automatic expect_job(input string tag, input logic [639:0] hdr, input logic [31:0] nn,
                            input int delay);
    wait_valid(tag);
    check({tag, "_header"}, bus.job_header, hdr);
    check({tag, "_nonce"}, bus.job_nonce, nn);
    check({tag, "_nonce_err"}, nonce_err, exp_nerr);
    check({tag, "_sync_err"}, sync_err_cnt, exp_sync);
    accept(tag, delay);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [639:0] hdr, hdr2;
    logic [31:0]  nn, nn2;
    logic [63:0]  w;
    int h0, h_stop, n, garb;
    bit good;

    rst_n = 1'b0;
    stop = 1'b1;
    bus.job_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_stop_ack", stop_ack, 1'b1);
    check("rst_job_valid", bus.job_valid, 1'b0);
    check("rst_hre", bus.hashin_fifo_re, 1'b0);
    check("rst_nre", bus.nonce_fifo_re, 1'b0);
    check("rst_header", bus.job_header, 640'h0);
    check("rst_nonce", bus.job_nonce, 32'h0);
    check("rst_sync", sync_err_cnt, 16'h0);
    check("rst_nerr", nonce_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_stop_ack", stop_ack, 1'b1);
    stop = 1'b0;
    @(negedge clk);
    check("hunt_stop_ack", stop_ack, 1'b0);

    // Directed job: counting words, nonce 0x0A embedded as 0x0A000000
    nq.push_back(32'h0000000A);
    hq.push_back(PRE);
    hdr = '0;
    for (int i = 0; i < 10; i++) begin
      w = 64'(i);
      if (i == 9) w = 64'h00000009_0A000000;
      hdr[639 - 64*i -: 64] = w;
      hq.push_back(w);
    end
    wait_valid("j1");
    check("j1_latency_ok", (cyc - last_pop) <= 4, 1'b1);
    check("j1_header", bus.job_header, hdr);
    check("j1_header_lo", bus.job_header[31:0], 32'h0A000000);
    check("j1_nonce", bus.job_nonce, 32'h0000000A);
    check("j1_nerr", nonce_err, 1'b0);
    accept("j1", 0);

    // Three garbage words ahead of a valid job
    for (int i = 0; i < 3; i++) hq.push_back(64'hDEADBEEF00000000);
    exp_sync += 3;
    push_job(0, 1'b1, -1, hdr, nn);
    expect_job("garb3", hdr, nn, 2);

    // Preamble value inside the header is data
    push_job(0, 1'b1, 3, hdr, nn);
    expect_job("pre_in_hdr", hdr, nn, 1);

    // Held job with the next one queued: outputs stable, no extra reads
    h0 = hreads;
    push_job(0, 1'b1, -1, hdr, nn);
    push_job(1, 1'b1, -1, hdr2, nn2);
    wait_valid("hold");
    for (int i = 0; i < 20; i++) begin
      check($sformatf("hold_hdr_%0d", i), bus.job_header, hdr);
      check($sformatf("hold_vld_%0d", i), bus.job_valid, 1'b1);
      @(negedge clk);
    end
    check("hold_nonce", bus.job_nonce, nn);
    check("hold_reads", hreads, h0 + 11);
    accept("hold", 0);
    exp_sync += 1;
    expect_job("hold_next", hdr2, nn2, 0);

    // Nonce mismatch: FIFO gives 1, header carries 0x02000000
    nq.push_back(32'h00000001);
    hq.push_back(PRE);
    hdr = '0;
    for (int i = 0; i < 10; i++) begin
      w = {$urandom, $urandom};
      if (i == 9) w[31:0] = 32'h02000000;
      hdr[639 - 64*i -: 64] = w;
      hq.push_back(w);
    end
    exp_nerr = 1'b1;
    expect_job("nbad", hdr, 32'h00000001, 0);
    push_job(0, 1'b1, -1, hdr, nn);
    expect_job("nsticky", hdr, nn, 0);

    // Random jobs
    for (int k = 0; k < 6; k++) begin
      garb = $urandom_range(0, 2);
      good = ($urandom_range(0, 3) != 0);
      push_job(garb, good, -1, hdr, nn);
      exp_sync += garb;
      if (!good) exp_nerr = 1'b1;
      expect_job($sformatf("rnd%0d", k), hdr, nn, $urandom_range(0, 3));
    end

    // Abort during LOAD after header word 5
    h0 = hreads;
    push_job(0, 1'b1, -1, hdr, nn);
    n = 0;
    while (hreads < h0 + 6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("stop_reached_w5", hreads, h0 + 6);
    stop = 1'b1;
    @(negedge clk);
    check("stop_ack", stop_ack, 1'b1);
    check("stop_hre", bus.hashin_fifo_re, 1'b0);
    h_stop = hreads;
    repeat (10) begin
      @(negedge clk);
      if (bus.job_valid !== 1'b0) check("stop_no_valid", bus.job_valid, 1'b0);
    end
    check("stop_valid", bus.job_valid, 1'b0);
    check("stop_reads_ceased", hreads, h_stop);
    check("stop_sync", sync_err_cnt, exp_sync);
    hq.delete();
    nq.delete();
    @(negedge clk);
    stop = 1'b0;

    // Reset while presenting a job
    push_job(0, 1'b1, -1, hdr, nn);
    wait_valid("rstp");
    rst_n = 1'b0;
    @(negedge clk);
    check("rstp_valid", bus.job_valid, 1'b0);
    check("rstp_header", bus.job_header, 640'h0);
    check("rstp_nonce", bus.job_nonce, 32'h0);
    check("rstp_stop_ack", stop_ack, 1'b1);
    check("rstp_sync", sync_err_cnt, 16'h0);
    check("rstp_nerr", nonce_err, 1'b0);
    rst_n = 1'b1;
    exp_sync = 0;
    exp_nerr = 1'b0;
    push_job(2, 1'b1, -1, hdr, nn);
    exp_sync += 2;
    expect_job("post_rst", hdr, nn, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
